// File: rtl/fifo_page_sched_if.sv
// Handshake bundle between the page scheduler and its surroundings: session
// control, FIFO enable/push/pop, downstream burst request and byte sink.
`timescale 1ns/1ps

interface fifo_page_sched_if #(
  parameter int RAM_SIZE  = 1024,
  parameter int PAGE_SIZE = 256
);
  localparam int LEN_W = $clog2(PAGE_SIZE + 1);
  localparam int LVL_W = $clog2(RAM_SIZE + 2);

  // session control
  logic             start_i;
  logic             stop_i;
  logic             abort_i;
  // buffer FIFO side
  logic             fifo_en_o;
  logic             fifo_push_i;
  logic             fifo_out_valid_i;
  logic             fifo_out_ready_o;
  // downstream burst handshake
  logic             burst_req_o;
  logic [LEN_W-1:0] burst_len_o;
  logic             burst_ack_i;
  // byte sink
  logic             sink_valid_o;
  logic             sink_ready_i;
  // status
  logic [LVL_W-1:0] level_o;
  logic             busy_o;
  logic             done_o;

  // scheduler side
  modport master (
    input  start_i, stop_i, abort_i, fifo_push_i, fifo_out_valid_i,
           burst_ack_i, sink_ready_i,
    output fifo_en_o, fifo_out_ready_o, burst_req_o, burst_len_o,
           sink_valid_o, level_o, busy_o, done_o
  );

  // environment side (FIFO, sink, session controller)
  modport slave (
    output start_i, stop_i, abort_i, fifo_push_i, fifo_out_valid_i,
           burst_ack_i, sink_ready_i,
    input  fifo_en_o, fifo_out_ready_o, burst_req_o, burst_len_o,
           sink_valid_o, level_o, busy_o, done_o
  );
endinterface

// File: rtl/fifo_page_sched.sv
// Page scheduler for a byte FIFO: tracks the buffered byte count, requests
// downstream bursts of up to one page, gates FIFO pops so that exactly the
// granted number of bytes leaves per burst, and flushes partial pages on
// stop or on an idle timeout.
`timescale 1ns/1ps

module fifo_page_sched #(
  parameter int RAM_SIZE       = 1024,
  parameter int PAGE_SIZE      = 256,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  fifo_page_sched_if.master bus
);

  localparam int LEN_W = $clog2(PAGE_SIZE + 1);
  localparam int LVL_W = $clog2(RAM_SIZE + 2);
  localparam int TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  // level counts RAM bytes plus the FIFO output register
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(RAM_SIZE + 1);
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] PAGE_LVL = LVL_W'(PAGE_SIZE);
  localparam logic [LEN_W-1:0] PAGE_LEN = LEN_W'(PAGE_SIZE);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic             TO_EN    = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_REQ   = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_r,     state_s;
  logic [LVL_W-1:0] level_r,     level_s;
  logic [LEN_W-1:0] len_r,       len_s;
  logic [LEN_W-1:0] rem_r,       rem_s;
  logic [TO_W-1:0]  to_cnt_r,    to_cnt_s;
  logic             stop_pend_r, stop_pend_s;

  logic en_s;        // FIFO enabled in the current state
  logic en_next_s;   // FIFO enabled in the state being entered
  logic burst_act_s; // bytes still owed to the current burst
  logic push_s;      // write that actually lands in the FIFO
  logic pop_s;       // byte handed to the sink this cycle
  logic to_exp_s;    // idle timeout reached

  // ---------------------------------------------------------------------
  // Decodes of the current state and registers
  // ---------------------------------------------------------------------
  assign en_s        = (state_r == ST_FILL) || (state_r == ST_REQ) || (state_r == ST_BURST);
  assign en_next_s   = (state_s == ST_FILL) || (state_s == ST_REQ) || (state_s == ST_BURST);
  assign burst_act_s = (state_r == ST_BURST) && (rem_r != LEN_ZERO);
  assign push_s      = bus.fifo_push_i & en_s;
  assign pop_s       = burst_act_s & bus.fifo_out_valid_i & bus.sink_ready_i;
  assign to_exp_s    = TO_EN && (to_cnt_r == TO_MAX);

  // ---------------------------------------------------------------------
  // Outputs: decoded from state and registers; only the pop handshake
  // passes through combinationally, and only while a burst owes bytes
  // ---------------------------------------------------------------------
  assign bus.fifo_en_o        = en_s;
  assign bus.busy_o           = (state_r != ST_IDLE);
  assign bus.done_o           = (state_r == ST_DONE);
  assign bus.burst_req_o      = (state_r == ST_REQ);
  assign bus.burst_len_o      = (state_r == ST_REQ) ? len_r : LEN_ZERO;
  assign bus.sink_valid_o     = burst_act_s & bus.fifo_out_valid_i;
  assign bus.fifo_out_ready_o = burst_act_s & bus.sink_ready_i;
  assign bus.level_o          = level_r;

  // State register and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_r     <= ST_IDLE;
      level_r     <= LVL_ZERO;
      len_r       <= LEN_ZERO;
      rem_r       <= LEN_ZERO;
      to_cnt_r    <= TO_ZERO;
      stop_pend_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      level_r     <= level_s;
      len_r       <= len_s;
      rem_r       <= rem_s;
      to_cnt_r    <= to_cnt_s;
      stop_pend_r <= stop_pend_s;
    end
  end

  // Next-state logic with burst length capture and remaining-byte count
  always_comb begin
    state_s = state_r;
    len_s   = len_r;
    rem_s   = rem_r;
    case (state_r)
      ST_IDLE: begin
        // stop and abort have no meaning before a session exists
        if (bus.start_i) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (bus.abort_i) begin
          state_s = ST_IDLE;
        end else if (level_r >= PAGE_LVL) begin
          state_s = ST_REQ;
          len_s   = PAGE_LEN;
        end else if (stop_pend_r && (level_r != LVL_ZERO)) begin
          // level is below one page here, so it fits the length field
          state_s = ST_REQ;
          len_s   = LEN_W'(level_r);
        end else if (stop_pend_r) begin
          state_s = ST_DONE;
        end else if (to_exp_s && (level_r != LVL_ZERO)) begin
          state_s = ST_REQ;
          len_s   = LEN_W'(level_r);
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_REQ: begin
        if (bus.abort_i) begin
          state_s = ST_IDLE;
        end else if (bus.burst_ack_i) begin
          state_s = ST_BURST;
          rem_s   = len_r;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_BURST: begin
        if (bus.abort_i) begin
          state_s = ST_IDLE;
        end else if (pop_s) begin
          rem_s = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            state_s = ST_FILL;
          end else begin
            state_s = ST_BURST;
          end
        end else begin
          state_s = ST_BURST;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        // unreachable encodings fall back to a clean idle
        state_s = ST_IDLE;
      end
    endcase
    // nothing owed or requested once the session is gone
    if (state_s == ST_IDLE) begin
      len_s = LEN_ZERO;
      rem_s = LEN_ZERO;
    end else begin
      len_s = len_s;
      rem_s = rem_s;
    end
  end

  // Buffered byte count; held at zero whenever the FIFO is disabled
  always_comb begin
    level_s = level_r;
    if (!en_next_s) begin
      level_s = LVL_ZERO;
    end else if (push_s && !pop_s && (level_r != LVL_MAX)) begin
      level_s = level_r + LVL_ONE;
    end else if (!push_s && pop_s && (level_r != LVL_ZERO)) begin
      level_s = level_r - LVL_ONE;
    end else begin
      level_s = level_r;
    end
  end

  // Idle counter for partial-page flush; only runs while waiting in FILL
  always_comb begin
    to_cnt_s = to_cnt_r;
    if ((state_r != ST_FILL) || (state_s != ST_FILL) || push_s) begin
      to_cnt_s = TO_ZERO;
    end else if (to_cnt_r != TO_MAX) begin
      to_cnt_s = to_cnt_r + TO_ONE;
    end else begin
      to_cnt_s = to_cnt_r;
    end
  end

  // Remembered stop request; dropped when the session returns to idle
  always_comb begin
    stop_pend_s = stop_pend_r;
    if ((state_r != ST_IDLE) && (state_s == ST_IDLE)) begin
      stop_pend_s = 1'b0;
    end else if ((state_r != ST_IDLE) && bus.stop_i) begin
      stop_pend_s = 1'b1;
    end else begin
      stop_pend_s = stop_pend_r;
    end
  end

endmodule

// File: tb/tb_fifo_page_sched.sv
// Self-checking bench for fifo_page_sched (RAM_SIZE=16, PAGE_SIZE=4,
// TIMEOUT_CYCLES=8): a cycle table, hand-written corner sequences and
// random sessions, all watched by a transaction-level reference model.
`timescale 1ns/1ps

module tb_fifo_page_sched;
  localparam int RAM    = 16;
  localparam int PAGE   = 4;
  localparam int TO     = 8;
  localparam int MAXLVL = RAM + 1;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  fifo_page_sched_if #(.RAM_SIZE(RAM), .PAGE_SIZE(PAGE)) bus();

  fifo_page_sched #(.RAM_SIZE(RAM), .PAGE_SIZE(PAGE), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // outputs captured at the falling edge
  int s_en, s_req, s_len, s_sv, s_ordy, s_level, s_busy, s_done;

  // reference model: byte count, owed bytes of the granted burst, totals
  int level_m, lvl_prev, outstanding, cur_len, n_push, n_pop;
  int req_prev, done_prev;

  typedef struct {
    logic start, stop, push, ack, ov, sready;
    int   en, req, len, sv, level, busy, done;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.abort_i = 1'b0;
    bus.fifo_push_i = 1'b0; bus.fifo_out_valid_i = 1'b0;
    bus.burst_ack_i = 1'b0; bus.sink_ready_i = 1'b0;
  endtask

  task automatic model_reset();
    level_m = 0; lvl_prev = 0; outstanding = 0; cur_len = 0;
    req_prev = 0; done_prev = 0;
  endtask

  task automatic capture();
    s_en    = int'(bus.fifo_en_o);
    s_req   = int'(bus.burst_req_o);
    s_len   = int'(bus.burst_len_o);
    s_sv    = int'(bus.sink_valid_o);
    s_ordy  = int'(bus.fifo_out_ready_o);
    s_level = int'(bus.level_o);
    s_busy  = int'(bus.busy_o);
    s_done  = int'(bus.done_o);
  endtask

  // Sample outputs, compare against the model, then advance the model
  task automatic sample_and_model();
    int push_acc, pop_now;
    capture();
    if (s_en == 0) begin
      chk("level_when_disabled", s_level, 0);
      level_m = 0;
      outstanding = 0;
    end else begin
      chk("level", s_level, level_m);
    end
    if (s_req != 0) begin
      if (req_prev == 0) begin
        cur_len = (lvl_prev >= PAGE) ? PAGE : lvl_prev;
        chk("burst_len_at_req", s_len, cur_len);
      end else begin
        chk("burst_len_stable", s_len, cur_len);
      end
    end else begin
      chk("burst_len_zero", s_len, 0);
    end
    if (outstanding == 0) begin
      chk("sink_valid_no_burst", s_sv, 0);
      chk("out_ready_no_burst", s_ordy, 0);
    end else begin
      chk("sink_valid", s_sv, int'(bus.fifo_out_valid_i));
      chk("out_ready", s_ordy, int'(bus.sink_ready_i));
    end
    pop_now  = s_sv & int'(bus.sink_ready_i);
    push_acc = int'(bus.fifo_push_i) & s_en;
    if (pop_now != 0) begin
      n_pop++;
      if (outstanding > 0) outstanding--;
    end
    if (push_acc != 0) n_push++;
    if ((s_req != 0) && bus.burst_ack_i) outstanding = cur_len;
    if (s_done != 0) begin
      chk("done_fifo_en", s_en, 0);
      chk("done_single_cycle", done_prev, 0);
    end
    done_prev = s_done;
    req_prev  = s_req;
    lvl_prev  = level_m;
    if (s_en != 0) level_m = level_m + push_acc - pop_now;
  endtask

  task automatic cycle();
    @(negedge clk);
    sample_and_model();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    capture();
    chk({tag, "_en"}, s_en, 0);
    chk({tag, "_req"}, s_req, 0);
    chk({tag, "_len"}, s_len, 0);
    chk({tag, "_sv"}, s_sv, 0);
    chk({tag, "_ordy"}, s_ordy, 0);
    chk({tag, "_level"}, s_level, 0);
    chk({tag, "_busy"}, s_busy, 0);
    chk({tag, "_done"}, s_done, 0);
  endtask

  function automatic vec_t mk(input logic st, sp, pu, ak, ov, sr,
                              input int en, rq, ln, sv, lv, bz, dn);
    vec_t v;
    v.start = st; v.stop = sp; v.push = pu; v.ack = ak; v.ov = ov; v.sready = sr;
    v.en = en; v.req = rq; v.len = ln; v.sv = sv; v.level = lv; v.busy = bz; v.done = dn;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   got, p0, q0, seen;
    int   lens[$];

    clear_inputs();
    model_reset();
    n_push = 0; n_pop = 0;

    // ---------------- reset state ----------------
    #1 rstn = 1'b0;
    bus.fifo_out_valid_i = 1'b1;
    bus.sink_ready_i     = 1'b1;
    #7 check_all_zero("reset");
    clear_inputs();
    #14 rstn = 1'b1;           // released at t=22, away from the edge
    @(posedge clk); #1;
    model_reset();

    // ---------------- cycle table: one full page, then stop when empty ----
    //              st sp pu ak ov sr   en rq ln sv lv bz dn
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 1, 1, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 2, 1, 0);
    tbl[4]  = mk(0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 3, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,   1, 1, 4, 0, 4, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 0,   1, 1, 4, 0, 4, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 1, 4, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 1, 3, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 1, 2, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 1, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      bus.start_i = tbl[i].start; bus.stop_i = tbl[i].stop;
      bus.fifo_push_i = tbl[i].push; bus.burst_ack_i = tbl[i].ack;
      bus.fifo_out_valid_i = tbl[i].ov; bus.sink_ready_i = tbl[i].sready;
      cycle();
      chk($sformatf("tbl%0d_en", i), s_en, tbl[i].en);
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
      chk($sformatf("tbl%0d_len", i), s_len, tbl[i].len);
      chk($sformatf("tbl%0d_sv", i), s_sv, tbl[i].sv);
      chk($sformatf("tbl%0d_level", i), s_level, tbl[i].level);
      chk($sformatf("tbl%0d_busy", i), s_busy, tbl[i].busy);
      chk($sformatf("tbl%0d_done", i), s_done, tbl[i].done);
    end
    clear_inputs();

    // ---------------- partial page flushed by idle timeout ----------------
    bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
    bus.fifo_push_i = 1'b1; repeat (3) cycle(); bus.fifo_push_i = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cycle();
      chk("timeout_early_req", s_req, 0);
    end
    got = 0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      cycle();
      if (s_req != 0) got = 1;
    end
    chk("timeout_req_seen", got, 1);
    chk("timeout_len", s_len, 3);
    bus.burst_ack_i = 1'b1; cycle(); bus.burst_ack_i = 1'b0;
    bus.sink_ready_i = 1'b1;
    p0 = n_pop;
    for (int k = 0; k < 8; k++) begin
      bus.fifo_out_valid_i = (level_m > 0);
      cycle();
    end
    chk("timeout_pops", n_pop - p0, 3);
    clear_inputs();
    bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      cycle();
      if (s_done != 0) seen = 1;
    end
    chk("timeout_done_seen", seen, 1);
    cycle();
    chk("timeout_end_busy", s_busy, 0);

    // ---------------- stop flushes a full page then the remainder ---------
    bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
    bus.fifo_push_i = 1'b1; repeat (6) cycle(); bus.fifo_push_i = 1'b0;
    bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
    bus.burst_ack_i = 1'b1; bus.sink_ready_i = 1'b1;
    seen = 0;
    lens.delete();
    for (int k = 0; k < 60 && seen == 0; k++) begin
      bus.fifo_out_valid_i = (level_m > 0);
      cycle();
      if (s_req != 0) lens.push_back(s_len);
      if (s_done != 0) begin
        seen = 1;
        chk("stop_done_en", s_en, 0);
      end
    end
    chk("stop_done_seen", seen, 1);
    chk("stop_burst_count", lens.size(), 2);
    if (lens.size() >= 2) begin
      chk("stop_burst0_len", lens[0], 4);
      chk("stop_burst1_len", lens[1], 2);
    end
    clear_inputs();
    cycle();
    chk("stop_end_busy", s_busy, 0);
    chk("stop_end_en", s_en, 0);

    // ---------------- full buffer, push+pop, abort mid-burst --------------
    bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
    bus.fifo_push_i = 1'b1; repeat (17) cycle(); bus.fifo_push_i = 1'b0;
    cycle();
    chk("level_max", s_level, 17);
    chk("level_max_req", s_req, 1);
    bus.burst_ack_i = 1'b1; cycle(); bus.burst_ack_i = 1'b0;
    bus.fifo_push_i = 1'b1; bus.sink_ready_i = 1'b1; bus.fifo_out_valid_i = 1'b1;
    cycle();
    chk("pushpop_pop", s_sv, 1);
    bus.fifo_push_i = 1'b0;
    cycle();
    chk("pushpop_level", s_level, 17);
    bus.abort_i = 1'b1; bus.sink_ready_i = 1'b0;
    cycle();
    chk("abort_level_before", s_level, 16);
    bus.abort_i = 1'b0; bus.sink_ready_i = 1'b1;
    p0 = n_pop;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("abort_en", s_en, 0);
      chk("abort_busy", s_busy, 0);
      chk("abort_level", s_level, 0);
      chk("abort_sv", s_sv, 0);
      chk("abort_ordy", s_ordy, 0);
      chk("abort_done", s_done, 0);
    end
    chk("abort_no_pops", n_pop - p0, 0);
    clear_inputs();

    // ---------------- reset asserted while a burst is requested -----------
    bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
    bus.fifo_push_i = 1'b1; repeat (4) cycle(); bus.fifo_push_i = 1'b0;
    cycle(); cycle();
    chk("pre_reset_req", s_req, 1);
    bus.sink_ready_i = 1'b1; bus.fifo_out_valid_i = 1'b1;
    #2 rstn = 1'b0;
    #1 check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    check_all_zero("inreset");
    clear_inputs();
    @(posedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
    cycle();
    chk("post_reset_en", s_en, 1);
    chk("post_reset_busy", s_busy, 1);
    chk("post_reset_req", s_req, 0);
    bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
    repeat (4) cycle();

    // ---------------- random sessions against the model -------------------
    for (int sess = 0; sess < 3; sess++) begin
      clear_inputs();
      bus.start_i = 1'b1; cycle(); bus.start_i = 1'b0;
      p0 = n_pop; q0 = n_push;
      for (int c = 0; c < 150; c++) begin
        bus.fifo_push_i      = (s_en != 0) && (level_m < MAXLVL) && ($urandom_range(0, 2) != 0);
        bus.sink_ready_i     = ($urandom_range(0, 1) != 0);
        bus.burst_ack_i      = ($urandom_range(0, 1) != 0);
        bus.fifo_out_valid_i = (level_m > 0) && ($urandom_range(0, 3) != 0);
        cycle();
      end
      bus.fifo_push_i = 1'b0;
      bus.stop_i = 1'b1; cycle(); bus.stop_i = 1'b0;
      seen = 0;
      for (int c = 0; c < 600 && seen == 0; c++) begin
        bus.sink_ready_i     = ($urandom_range(0, 1) != 0);
        bus.burst_ack_i      = ($urandom_range(0, 1) != 0);
        bus.fifo_out_valid_i = (level_m > 0) && ($urandom_range(0, 3) != 0);
        cycle();
        if (s_done != 0) seen = 1;
      end
      chk("rand_done_seen", seen, 1);
      chk("rand_drained", n_pop - p0, n_push - q0);
      clear_inputs();
      cycle();
      chk("rand_end_busy", s_busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
